fft_addr_seq: RTL and testbench

Self-sequencing address generator for the four-bank radix-4 in-place FFT memory. On `start` it walks through three phases: load (digit-reversed write addresses), STAGES butterfly stages, and output (natural order). It drives registered per-bank addresses A..D every enabled cycle, with the counter owned internally. The bank memories and butterfly datapath consume its outputs, and `en` provides datapath backpressure.

---
 rtl/fft_pkg.sv | 29 ++
 rtl/fft_addr_seq_if.sv | 37 +++
 rtl/fft_addr_map.sv | 61 ++++++
 rtl/fft_addr_seq.sv | 139 +++++++++++++
 tb/tb_fft_addr_seq.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/fft_pkg.sv
// Shared types and helpers for the radix-4 FFT address sequencer.
// Provides the phase encoding and a base-4 digit reversal function.
package fft_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    COMP = 2'd2,
    OUT  = 2'd3
  } phase_t;

  localparam int DIGIT_REV_MAX = 16;

  // Reverse the order of the lowest `digits` base-4 digits of val.
  function automatic logic [31:0] digit_rev(input logic [31:0] val, input int digits);
    logic [31:0] r;
    logic [31:0] v;
    r = '0;
    v = val;
    for (int i = 0; i < DIGIT_REV_MAX; i++) begin
      if (i < digits) begin
        r = {r[29:0], v[1:0]};
        v = v >> 2;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_addr_seq_if.sv
// Port bundle of the FFT address sequencer: control inputs and the
// registered per-bank address/status outputs.
interface fft_addr_seq_if
  import fft_pkg::*;
#(
  parameter int STAGES = 4,
  parameter int ADDR_W = 2 * STAGES,
  parameter int STG_W  = $clog2(STAGES) + 1
);

  logic              start;
  logic              en;
  logic              abort;
  phase_t            phase;
  logic [STG_W-1:0]  stage;
  logic [1:0]        sub;
  logic [ADDR_W-1:0] a_addr;
  logic [ADDR_W-1:0] b_addr;
  logic [ADDR_W-1:0] c_addr;
  logic [ADDR_W-1:0] d_addr;
  logic              valid;
  logic              last;
  logic              done;

  // Handshake: en is the consumer's ready; an output beat is transferred
  // on every rising edge where valid & en, and nothing moves while en=0.
  modport master (
    input  start, en, abort,
    output phase, stage, sub, a_addr, b_addr, c_addr, d_addr, valid, last, done
  );

  modport slave (
    output start, en, abort,
    input  phase, stage, sub, a_addr, b_addr, c_addr, d_addr, valid, last, done
  );

endinterface

// File: rtl/fft_addr_map.sv
// Combinational (phase, stage, cnt) -> four bank addresses.
// Define FFT_ADDR_DIGIT_REV_EN to digit-reverse the LOAD addresses.
module fft_addr_map
  import fft_pkg::*;
#(
  parameter int STAGES = 4,
  parameter int ADDR_W = 2 * STAGES,
  parameter int STG_W  = $clog2(STAGES) + 1
) (
  input  phase_t            phase,
  input  logic [STG_W-1:0]  stage,
  input  logic [ADDR_W-1:0] cnt,
  output logic [ADDR_W-1:0] a_addr,
  output logic [ADDR_W-1:0] b_addr,
  output logic [ADDR_W-1:0] c_addr,
  output logic [ADDR_W-1:0] d_addr
);

  logic [ADDR_W-1:0] addr [4];
  logic [ADDR_W-1:0] bfly;
  logic [ADDR_W-1:0] load_addr;
  int                pos;

`ifdef FFT_ADDR_DIGIT_REV_EN
  logic [31:0] rev;
  always_comb begin
    rev       = digit_rev(32'(cnt), STAGES);
    load_addr = rev[ADDR_W-1:0];
  end
`else
  assign load_addr = cnt;
`endif

  always_comb begin
    bfly = cnt >> 2;
    pos  = STAGES - int'(stage);
    for (int j = 0; j < 4; j++) addr[j] = '0;
    case (phase)
      LOAD: for (int j = 0; j < 4; j++) addr[j] = load_addr;
      COMP: begin
        // Digits below pos come from the butterfly index unchanged; the bank
        // digit sits at pos and the remaining index digits move up by one.
        for (int j = 0; j < 4; j++) begin
          for (int k = 0; k < STAGES; k++) begin
            if (k < pos)       addr[j][2*k +: 2] = bfly[2*k +: 2];
            else if (k == pos) addr[j][2*k +: 2] = 2'(j);
            else               addr[j][2*k +: 2] = cnt[2*k +: 2];
          end
        end
      end
      OUT:  for (int j = 0; j < 4; j++) addr[j] = cnt;
      default: ;
    endcase
  end

  assign a_addr = addr[0];
  assign b_addr = addr[1];
  assign c_addr = addr[2];
  assign d_addr = addr[3];

endmodule

// File: rtl/fft_addr_seq.sv
// Self-sequencing four-bank address generator for an in-place radix-4 FFT:
// LOAD, STAGES compute stages, OUT. LOAD order depends on FFT_ADDR_DIGIT_REV_EN.
module fft_addr_seq
  import fft_pkg::*;
#(
  parameter int STAGES = 4,
  parameter int ADDR_W = 2 * STAGES,
  parameter int STG_W  = $clog2(STAGES) + 1
) (
  input logic            clk,
  input logic            rst_n,
  fft_addr_seq_if.master bus
);

  phase_t            phase_q, phase_d;
  logic [STG_W-1:0]  stage_q, stage_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              done_q, done_d;
  logic              cnt_end;

  logic [ADDR_W-1:0] a_q, b_q, c_q, d_q;
  logic [ADDR_W-1:0] a_d, b_d, c_d, d_d;
  logic              valid_q, valid_d;
  logic              last_q, last_d;

  assign cnt_end = (cnt_q == '1);

  always_comb begin
    phase_d = phase_q;
    stage_d = stage_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    if (bus.abort) begin
      phase_d = IDLE;
      stage_d = '0;
      cnt_d   = '0;
      done_d  = 1'b0;
    end else if (bus.en) begin
      done_d = 1'b0;
      case (phase_q)
        IDLE: begin
          if (bus.start) begin
            phase_d = LOAD;
            cnt_d   = '0;
          end
        end
        LOAD: begin
          if (cnt_end) begin
            phase_d = COMP;
            stage_d = STG_W'(1);
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + ADDR_W'(1);
          end
        end
        COMP: begin
          if (cnt_end) begin
            cnt_d = '0;
            if (stage_q == STG_W'(STAGES)) begin
              phase_d = OUT;
              stage_d = '0;
            end else begin
              stage_d = stage_q + STG_W'(1);
            end
          end else begin
            cnt_d = cnt_q + ADDR_W'(1);
          end
        end
        OUT: begin
          if (cnt_end) begin
            phase_d = IDLE;
            cnt_d   = '0;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + ADDR_W'(1);
          end
        end
        default: phase_d = IDLE;
      endcase
    end
  end

  // Addresses are mapped from the next state so they leave a register
  // in the same cycle as the phase/stage/count they belong to.
  fft_addr_map #(
    .STAGES(STAGES),
    .ADDR_W(ADDR_W),
    .STG_W (STG_W)
  ) u_map (
    .phase (phase_d),
    .stage (stage_d),
    .cnt   (cnt_d),
    .a_addr(a_d),
    .b_addr(b_d),
    .c_addr(c_d),
    .d_addr(d_d)
  );

  assign valid_d = (phase_d != IDLE);
  assign last_d  = (cnt_d == '1) && (phase_d != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= IDLE;
      stage_q <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      d_q     <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      phase_q <= phase_d;
      stage_q <= stage_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      d_q     <= d_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  assign bus.phase  = phase_q;
  assign bus.stage  = stage_q;
  assign bus.sub    = cnt_q[1:0];
  assign bus.a_addr = a_q;
  assign bus.b_addr = b_q;
  assign bus.c_addr = c_q;
  assign bus.d_addr = d_q;
  assign bus.valid  = valid_q;
  assign bus.last   = last_q;
  assign bus.done   = done_q;

endmodule

// File: tb/tb_fft_addr_seq.sv
// Bench for fft_addr_seq (STAGES=4): transform-position reference model,
// spot-value table and hand-written abort/reset/backpressure sequences.
module tb_fft_addr_seq;

  localparam int STAGES = 4;
  localparam int AW     = 2 * STAGES;
  localparam int SW     = $clog2(STAGES) + 1;
  localparam int N      = 4 ** STAGES;
  localparam int TOTAL  = (STAGES + 2) * N;
  localparam int W      = 2 + SW + 2 + 4 * AW + 3;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  fft_addr_seq_if #(.STAGES(STAGES)) bus ();

  fft_addr_seq #(.STAGES(STAGES)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int              n_checks;
  int              n_errors;
  logic [W-1:0]    exp_q[$];
  int              en_valid_cnt;
  bit              rec_en;
  logic [4*AW-1:0] obs_addr [TOTAL];

  // Reference model: a transform is a single position m_t in 0..TOTAL-1.
  bit m_busy;
  bit m_done;
  int m_t;

  typedef struct {
    int          pi;
    int          cnt;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int model_addr(input int pi, input int cnt, input int j);
    int b, w, r, x;
    if (pi == 0) begin
`ifdef FFT_ADDR_DIGIT_REV_EN
      r = 0;
      x = cnt;
      for (int i = 0; i < STAGES; i++) begin
        r = r * 4 + x % 4;
        x = x / 4;
      end
      return r;
`else
      return cnt;
`endif
    end else if (pi <= STAGES) begin
      b = cnt / 4;
      w = 1;
      repeat (STAGES - pi) w = w * 4;
      return ((b / w) * 4 + j) * w + (b % w);
    end
    return cnt;
  endfunction

  function automatic logic [W-1:0] exp_word();
    int               pi, cnt;
    logic [1:0]       ph;
    logic [SW-1:0]    st;
    logic [AW-1:0]    ad [4];
    if (!m_busy) return {{(W-1){1'b0}}, m_done};
    pi  = m_t / N;
    cnt = m_t % N;
    if (pi == 0) begin
      ph = 2'd1; st = '0;
    end else if (pi <= STAGES) begin
      ph = 2'd2; st = SW'(pi);
    end else begin
      ph = 2'd3; st = '0;
    end
    for (int j = 0; j < 4; j++) ad[j] = AW'(model_addr(pi, cnt, j));
    return {ph, st, 2'(cnt % 4), ad[0], ad[1], ad[2], ad[3], 1'b1, cnt == N - 1, 1'b0};
  endfunction

  function automatic logic [W-1:0] obs_word();
    return {bus.phase, bus.stage, bus.sub, bus.a_addr, bus.b_addr, bus.c_addr,
            bus.d_addr, bus.valid, bus.last, bus.done};
  endfunction

  task automatic model_edge(input logic s, input logic e, input logic a);
    if (a) begin
      m_busy = 1'b0;
      m_done = 1'b0;
    end else if (e) begin
      if (!m_busy) begin
        m_done = 1'b0;
        if (s) begin
          m_busy = 1'b1;
          m_t    = 0;
        end
      end else if (m_t == TOTAL - 1) begin
        m_busy = 1'b0;
        m_done = 1'b1;
      end else begin
        m_t++;
      end
    end
  endtask

  // ---------------- driver ----------------
  // Called at a falling edge: drive, take the rising edge, check at the next fall.
  task automatic step(input logic s, input logic e, input logic a);
    logic [W-1:0] exp;
    if (bus.valid && e) en_valid_cnt++;
    bus.start = s;
    bus.en    = e;
    bus.abort = a;
    @(posedge clk);
    model_edge(s, e, a);
    exp_q.push_back(exp_word());
    @(negedge clk);
    if (exp_q.size() == 0) begin
      check("sb_empty", 1, 0);
    end else begin
      exp = exp_q.pop_front();
      check("cycle", obs_word(), exp);
    end
    if (rec_en && m_busy)
      obs_addr[m_t] = {bus.a_addr, bus.b_addr, bus.c_addr, bus.d_addr};
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: cycle budget expired, got busy expected idle", name);
  endtask

  // ---------------- test ----------------
  initial begin
    logic [W-1:0] frozen;
    logic [31:0]  rev_1b;
    int           guard;
    bit           burst_done;

`ifdef FFT_ADDR_DIGIT_REV_EN
    rev_1b = 32'hE4E4E4E4;
`else
    rev_1b = 32'h1B1B1B1B;
`endif
    tbl[0]  = '{0, 8'h00, 32'h00000000};
    tbl[1]  = '{0, 8'h1B, rev_1b};
    tbl[2]  = '{1, 8'h34, 32'h0D4D8DCD};
    tbl[3]  = '{1, 8'h35, 32'h0D4D8DCD};
    tbl[4]  = '{1, 8'h36, 32'h0D4D8DCD};
    tbl[5]  = '{1, 8'h37, 32'h0D4D8DCD};
    tbl[6]  = '{4, 8'h34, 32'h34353637};
    tbl[7]  = '{4, 8'h35, 32'h34353637};
    tbl[8]  = '{4, 8'h36, 32'h34353637};
    tbl[9]  = '{4, 8'h37, 32'h34353637};
    tbl[10] = '{5, 8'hA5, 32'hA5A5A5A5};
    tbl[11] = '{2, 8'h37, 32'h0D1D2D3D};

    n_checks = 0;
    n_errors = 0;
    m_busy   = 1'b0;
    m_done   = 1'b0;
    m_t      = 0;
    rec_en   = 1'b0;
    bus.start = 1'b0;
    bus.en    = 1'b0;
    bus.abort = 1'b0;
    rst_n     = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check("reset", obs_word(), '0);

    // Full transform with en held high.
    en_valid_cnt = 0;
    rec_en       = 1'b1;
    step(1, 1, 0);
    for (int i = 0; i < TOTAL; i++) step(0, 1, 0);
    rec_en = 1'b0;
    check("done_pulse", bus.done, 1);
    step(0, 1, 0);
    check("done_clear", {bus.done, bus.phase}, 0);
    check("valid_cycles", en_valid_cnt, TOTAL);
    for (int i = 0; i < 12; i++)
      check($sformatf("tbl%0d", i), obs_addr[tbl[i].pi * N + tbl[i].cnt], tbl[i].exp);

    // Random backpressure, a 10-cycle stall mid stage 2, starts while busy.
    en_valid_cnt = 0;
    burst_done   = 1'b0;
    guard        = 0;
    step(1, 1, 0);
    while (m_busy && guard < 8000) begin
      guard++;
      if (!burst_done && m_t >= 2 * N + 100) begin
        burst_done = 1'b1;
        frozen     = obs_word();
        repeat (10) step(1'($urandom_range(0, 1)), 0, 0);
        check("freeze", obs_word(), frozen);
      end else begin
        step(($urandom_range(0, 15) == 0) || (m_t == 5 * N + 10),
             ($urandom_range(0, 3) != 0), 0);
      end
    end
    if (m_busy) timeout("random_run");
    check("valid_cycles_bp", en_valid_cnt, TOTAL);

    // Back-to-back: start in the cycle done is high.
    check("done_before_b2b", bus.done, 1);
    step(1, 1, 0);
    check("b2b_load", {bus.phase, bus.valid}, {2'd1, 1'b1});

    // Abort during stage 3, with a simultaneous start.
    guard = 0;
    while (m_busy && m_t < 3 * N + 40 && guard < 2000) begin
      guard++;
      step(0, 1, 0);
    end
    if (m_t < 3 * N + 40) timeout("reach_stage3");
    step(1, 1, 1);
    check("abort_idle", {bus.phase, bus.valid, bus.done}, 0);
    step(1, 1, 0);
    check("restart_load", {bus.phase, bus.a_addr, bus.valid}, {2'd1, 8'h00, 1'b1});

    // Abort with en low.
    repeat (5) step(0, 1, 0);
    step(0, 0, 1);
    check("abort_no_en", {bus.phase, bus.valid}, 0);

    // Async reset mid-LOAD.
    step(1, 1, 0);
    repeat (20) step(0, 1, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", obs_word(), '0);
    m_busy = 1'b0;
    m_done = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Start with en low is ignored, then a normal start.
    step(1, 0, 0);
    check("start_no_en", bus.phase, 0);
    step(0, 1, 0);
    step(1, 1, 0);
    repeat (8) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
